// File: rtl/multi_encoder_decoder.sv
// N-channel quadrature encoder front end: synchroniser, deglitch, position,
// step period, direction and sticky illegal-transition flag per channel.
module multi_encoder_decoder #(
  parameter int unsigned NCH       = 3,
  parameter int unsigned POS_WIDTH = 16,
  parameter int unsigned PER_WIDTH = 16,
  parameter int unsigned DGL_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*NCH-1:0]     enc_i,
  input  logic [7:0]           sample_div_i,
  input  logic [DGL_WIDTH-1:0] dgl_len_i,
  input  logic                 we_i,
  input  logic [3:0]           wa_i,
  input  logic [POS_WIDTH-1:0] wd_i,
  input  logic [3:0]           rsel_i,
  input  logic                 clr_err_i,
  output logic [POS_WIDTH-1:0] pos_o,
  output logic [PER_WIDTH-1:0] period_o,
  output logic                 dir_o,
  output logic [NCH-1:0]       err_o,
  output logic [NCH-1:0]       step_o
);

  logic [7:0]           presc_q, presc_d;
  logic                 strobe_c;
  logic [1:0]           sync1_q [NCH], sync1_d [NCH];
  logic [1:0]           sync2_q [NCH], sync2_d [NCH];
  logic [1:0]           cand_q  [NCH], cand_d  [NCH];
  logic [1:0]           filt_q  [NCH], filt_d  [NCH];
  logic [DGL_WIDTH-1:0] dcnt_q  [NCH], dcnt_d  [NCH];
  logic [POS_WIDTH-1:0] pos_q   [NCH], pos_d   [NCH];
  logic [PER_WIDTH-1:0] pcnt_q  [NCH], pcnt_d  [NCH];
  logic [PER_WIDTH-1:0] per_q   [NCH], per_d   [NCH];
  logic [NCH-1:0]       init_q, init_d, dir_q, dir_d, err_q, err_d, step_q, step_d;
  logic [NCH-1:0]       acc_c, cnt_c, bad_c;
  logic [1:0]           dlt_c   [NCH];
  logic [POS_WIDTH-1:0] pos_rb_c;
  logic [PER_WIDTH-1:0] per_rb_c;
  logic                 dir_rb_c;

  // Gray state to a binary phase so a legal step is +/-1 mod 4
  function automatic logic [1:0] phase(input logic [1:0] e);
    return {e[1], e[1] ^ e[0]};
  endfunction

  always_comb begin
    strobe_c = (presc_q == sample_div_i);
    presc_d  = strobe_c ? 8'd0 : presc_q + 8'd1;
    for (int i = 0; i < NCH; i++) begin
      sync1_d[i] = enc_i[2*i +: 2];
      sync2_d[i] = sync1_q[i];
      cand_d[i]  = cand_q[i];
      filt_d[i]  = filt_q[i];
      dcnt_d[i]  = dcnt_q[i];
      pos_d[i]   = pos_q[i];
      pcnt_d[i]  = pcnt_q[i];
      per_d[i]   = per_q[i];
      init_d[i]  = init_q[i];
      dir_d[i]   = dir_q[i];
      step_d[i]  = 1'b0;
      acc_c[i]   = 1'b0;
      cnt_c[i]   = 1'b0;
      bad_c[i]   = 1'b0;
      dlt_c[i]   = 2'(phase(cand_q[i]) - phase(filt_q[i]));

      if (strobe_c) begin
        if (pcnt_q[i] != '1) pcnt_d[i] = pcnt_q[i] + PER_WIDTH'(1);
        if (sync2_q[i] != cand_q[i]) begin
          cand_d[i] = sync2_q[i];
          dcnt_d[i] = '0;
        end else if (cand_q[i] != filt_q[i]) begin
          if (dcnt_q[i] == dgl_len_i) begin
            filt_d[i] = cand_q[i];
            dcnt_d[i] = '0;
            acc_c[i]  = 1'b1;
          end else begin
            dcnt_d[i] = dcnt_q[i] + DGL_WIDTH'(1);
          end
        end else begin
          dcnt_d[i] = '0;
        end
      end

      if (pcnt_q[i] == '1) per_d[i] = '1;

      // First acceptance after reset only establishes the reference
      if (acc_c[i]) begin
        if (!init_q[i]) begin
          init_d[i] = 1'b1;
        end else begin
          cnt_c[i] = (dlt_c[i] == 2'd1) || (dlt_c[i] == 2'd3);
          bad_c[i] = (dlt_c[i] == 2'd2);
        end
      end

      if (cnt_c[i]) begin
        pos_d[i]  = (dlt_c[i] == 2'd1) ? pos_q[i] + POS_WIDTH'(1) : pos_q[i] - POS_WIDTH'(1);
        per_d[i]  = pcnt_q[i];
        pcnt_d[i] = '0;
        dir_d[i]  = (dlt_c[i] == 2'd3);
        step_d[i] = 1'b1;
      end

      if (we_i && (wa_i == 4'(i))) pos_d[i] = wd_i;
      err_d[i] = bad_c[i] | (err_q[i] & ~clr_err_i);
    end
  end

  always_comb begin
    pos_rb_c = '0;
    per_rb_c = '0;
    dir_rb_c = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (rsel_i == 4'(i)) begin
        pos_rb_c = pos_q[i];
        per_rb_c = per_q[i];
        dir_rb_c = dir_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q  <= '0;
      init_q   <= '0;
      dir_q    <= '0;
      err_q    <= '0;
      step_q   <= '0;
      pos_o    <= '0;
      period_o <= '0;
      dir_o    <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        sync1_q[i] <= '0;
        sync2_q[i] <= '0;
        cand_q[i]  <= '0;
        filt_q[i]  <= '0;
        dcnt_q[i]  <= '0;
        pos_q[i]   <= '0;
        pcnt_q[i]  <= '0;
        per_q[i]   <= '0;
      end
    end else begin
      presc_q  <= presc_d;
      init_q   <= init_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
      step_q   <= step_d;
      pos_o    <= pos_rb_c;
      period_o <= per_rb_c;
      dir_o    <= dir_rb_c;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cand_q   <= cand_d;
      filt_q   <= filt_d;
      dcnt_q   <= dcnt_d;
      pos_q    <= pos_d;
      pcnt_q   <= pcnt_d;
      per_q    <= per_d;
    end
  end

  assign err_o  = err_q;
  assign step_o = step_q;

endmodule

// File: tb/tb_multi_encoder_decoder.sv
// Scoreboard bench for multi_encoder_decoder: a per-channel quadrature model
// queues expected steps; a monitor pops them when the DUT pulses step_o.
module tb_multi_encoder_decoder;
  localparam int unsigned NCH = 3, POS_WIDTH = 16, PER_WIDTH = 8, DGL_WIDTH = 4;

  logic                 clk = 1'b0, rst = 1'b1;
  logic [2*NCH-1:0]     enc = '0;
  logic [7:0]           sample_div = '0;
  logic [DGL_WIDTH-1:0] dgl_len = '0;
  logic                 we = 1'b0, clr_err = 1'b0;
  logic [3:0]           wa = '0, rsel = '0;
  logic [POS_WIDTH-1:0] wd = '0, pos_o;
  logic [PER_WIDTH-1:0] period_o;
  logic                 dir_o;
  logic [NCH-1:0]       err_o, step_o;

  multi_encoder_decoder #(.NCH(NCH), .POS_WIDTH(POS_WIDTH), .PER_WIDTH(PER_WIDTH),
                          .DGL_WIDTH(DGL_WIDTH)) dut (
    .clk(clk), .rst(rst), .enc_i(enc), .sample_div_i(sample_div), .dgl_len_i(dgl_len),
    .we_i(we), .wa_i(wa), .wd_i(wd), .rsel_i(rsel), .clr_err_i(clr_err),
    .pos_o(pos_o), .period_o(period_o), .dir_o(dir_o), .err_o(err_o), .step_o(step_o));

  always #5 clk = ~clk;

  typedef struct { int ch; logic [POS_WIDTH-1:0] pos; logic dir; } exp_t;
  exp_t sb_q[$];
  exp_t pend_e;
  logic pend = 1'b0;

  int n_cmp = 0, n_err = 0, cyc = 0, drive_cyc = 0, step_cyc = 0;
  logic [1:0]           m_prev [NCH];
  logic                 m_init [NCH];
  logic [POS_WIDTH-1:0] m_pos  [NCH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] phase(input logic [1:0] e);
    return {e[1], e[1] ^ e[0]};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_apply(input int c, input logic [1:0] v);
    logic [1:0] d;
    exp_t e;
    if (v == m_prev[c]) return;
    if (!m_init[c]) begin
      m_init[c] = 1'b1;
    end else begin
      d = 2'(phase(v) - phase(m_prev[c]));
      if (d == 2'd1 || d == 2'd3) begin
        m_pos[c] = (d == 2'd1) ? m_pos[c] + 16'd1 : m_pos[c] - 16'd1;
        e.ch = c; e.pos = m_pos[c]; e.dir = (d == 2'd3);
        sb_q.push_back(e);
      end
    end
    m_prev[c] = v;
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_prev[c] = 2'b00; m_init[c] = 1'b0; m_pos[c] = '0;
    end
    sb_q.delete();
    for (int c = 0; c < NCH; c++) model_apply(c, enc[2*c +: 2]);
  endtask

  task automatic drive(input int c, input logic [1:0] v, input int hold);
    enc[2*c +: 2] = v;
    model_apply(c, v);
    drive_cyc = cyc;
    tick(hold);
  endtask

  task automatic write_pos(input int a, input logic [POS_WIDTH-1:0] v);
    we = 1'b1; wa = 4'(a); wd = v;
    tick(1);
    we = 1'b0;
    if (a < NCH) m_pos[a] = v;
    tick(2);
  endtask

  // Step monitor: position/direction become visible on the readback one clk later
  always @(negedge clk) begin
    if (pend) begin
      chk("pos_at_step", 32'(pos_o), 32'(pend_e.pos));
      chk("dir_at_step", 32'(dir_o), 32'(pend_e.dir));
      pend = 1'b0;
    end
    if (step_o != '0) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_step", 32'(step_o), 32'd0);
      end else begin
        pend_e = sb_q.pop_front();
        chk("step_ch", 32'(step_o), 32'd1 << pend_e.ch);
        pend = 1'b1;
        step_cyc = cyc;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;
    for (int c = 0; c < NCH; c++) begin
      m_prev[c] = 2'b00; m_init[c] = 1'b0; m_pos[c] = '0;
    end
    tick(3);
    chk("rst_pos", 32'(pos_o), 0); chk("rst_per", 32'(period_o), 0);
    chk("rst_dir", 32'(dir_o), 0); chk("rst_err", 32'(err_o), 0);
    chk("rst_step", 32'(step_o), 0);
    rst = 1'b0;
    tick(2);

    // Forward on ch0: 01 sets the reference, then four counts
    rsel = 4'd0;
    drive(0, 2'b01, 8); drive(0, 2'b11, 8); drive(0, 2'b10, 8);
    drive(0, 2'b00, 8); drive(0, 2'b01, 8);
    chk("fwd_pos", 32'(pos_o), 32'd4); chk("fwd_dir", 32'(dir_o), 0);
    chk("fwd_err", 32'(err_o), 0);

    // Reverse on ch1, then write and wrap past 0x7FFF
    rsel = 4'd1;
    drive(1, 2'b01, 8); drive(1, 2'b00, 8); drive(1, 2'b10, 8);
    drive(1, 2'b11, 8); drive(1, 2'b01, 8);
    chk("rev_pos", 32'(pos_o), 32'hFFFC); chk("rev_dir", 32'(dir_o), 1);
    write_pos(1, 16'h7FFF);
    chk("wr_pos", 32'(pos_o), 32'h7FFF);
    write_pos(5, 16'h1234);
    chk("wr_ignored", 32'(pos_o), 32'h7FFF);
    drive(1, 2'b11, 8);
    chk("wrap_pos", 32'(pos_o), 32'h8000);

    // Illegal jump on ch2 and sticky error handling
    rsel = 4'd2;
    drive(2, 2'b01, 8); drive(2, 2'b11, 8); drive(2, 2'b00, 8);
    chk("err_set", 32'(err_o), 32'b100); chk("err_pos", 32'(pos_o), 32'd1);
    clr_err = 1'b1; tick(1); clr_err = 1'b0; tick(1);
    chk("err_clr", 32'(err_o), 0);
    clr_err = 1'b1;
    drive(2, 2'b11, 0);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (err_o[2]) begin seen = 1'b1; clr_err = 1'b0; end
    end
    clr_err = 1'b0;
    chk("err_set_wins", 32'(seen), 1);
    tick(3);
    chk("err_sticky", 32'(err_o), 32'b100); chk("err_pos2", 32'(pos_o), 32'd1);
    clr_err = 1'b1; tick(1); clr_err = 1'b0; tick(1);
    chk("err_clr2", 32'(err_o), 0);

    // Period on ch0: steps 40 clk apart, then a long stall saturates
    rsel = 4'd0;
    drive(0, 2'b11, 40); drive(0, 2'b10, 40); drive(0, 2'b00, 40);
    chk("period_39", 32'(period_o), 32'd39);
    tick(300);
    chk("period_stall", 32'(period_o), 32'hFF);
    rsel = 4'd5; tick(2);
    chk("rb_oor_pos", 32'(pos_o), 0); chk("rb_oor_per", 32'(period_o), 0);
    chk("rb_oor_dir", 32'(dir_o), 0);

    // Deglitch on ch1 with strobe every 4 clk and two extra stable strobes
    rsel = 4'd1; sample_div = 8'd3; dgl_len = 4'd2;
    tick(4);
    enc[3:2] = 2'b10; tick(1); enc[3:2] = 2'b11; tick(30);
    enc[3:2] = 2'b10; tick(11); enc[3:2] = 2'b11; tick(30);
    chk("glitch_pos", 32'(pos_o), 32'h8000);
    step_cyc = 0;
    drive(1, 2'b10, 30);
    lat = step_cyc - drive_cyc;
    chk("dgl_latency_ok", 32'(lat >= 15 && lat <= 18), 1);
    chk("dgl_pos", 32'(pos_o), 32'h8001);

    // Reset mid-sequence with ch0 held at 10
    sample_div = 8'd0; dgl_len = 4'd0;
    rst = 1'b1; tick(1); rst = 1'b0;
    model_reset();
    tick(10);
    rsel = 4'd0;
    drive(0, 2'b01, 8); drive(0, 2'b11, 8); drive(0, 2'b10, 8);
    chk("pre_rst_pos", 32'(pos_o), 32'd2);
    rst = 1'b1; tick(1);
    chk("mid_rst_pos", 32'(pos_o), 0); chk("mid_rst_per", 32'(period_o), 0);
    chk("mid_rst_dir", 32'(dir_o), 0); chk("mid_rst_err", 32'(err_o), 0);
    chk("mid_rst_step", 32'(step_o), 0);
    rst = 1'b0;
    model_reset();
    tick(10);
    chk("reinit_pos", 32'(pos_o), 0);
    drive(0, 2'b00, 8);
    chk("post_rst_pos1", 32'(pos_o), 32'd1);
    drive(0, 2'b01, 8);
    chk("post_rst_pos2", 32'(pos_o), 32'd2);

    tick(5);
    chk("sb_empty", 32'(sb_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
